// File: rtl/cdb_pkg.sv
// Shared constants and the broadcast record for the common data bus: sizes,
// requester slot numbers, and the {valid, tag, data} struct used by the arbiter, adders and RS.
package cdb_pkg;

  localparam int NREQ       = 6;
  localparam int TAG_WIDTH  = 4;
  localparam int DATA_WIDTH = 32;
  localparam int SRC_WIDTH  = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Requester slots on the bus; MEM is always the last slot.
  localparam int ADD1 = 0;
  localparam int ADD2 = 1;
  localparam int ADD3 = 2;
  localparam int MUL1 = 3;
  localparam int MUL2 = 4;
  localparam int MEM  = 5;

  typedef struct packed {
    logic                  valid;
    logic [TAG_WIDTH-1:0]  tag;
    logic [DATA_WIDTH-1:0] data;
  } cdb_bcast_t;

endpackage

// File: rtl/cdb_arbiter_if.sv
// Requester-side bundle of the CDB arbiter. Requesters drive it through the master modport.
// The arbiter drives it through the slave modport.
interface cdb_arbiter_if #(
  parameter int NREQ       = cdb_pkg::NREQ,
  parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
  parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH
) ();
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]            req_valid;
  logic [NREQ*TAG_WIDTH-1:0]  req_tag;
  logic [NREQ*DATA_WIDTH-1:0] req_data;
  logic [NREQ-1:0]            req_ready;
  logic                       cdb_valid;
  logic [TAG_WIDTH-1:0]       cdb_tag;
  logic [DATA_WIDTH-1:0]      cdb_data;
  logic [SW-1:0]              cdb_src;
  logic                       err_tag0;

  modport master (
    output req_valid, req_tag, req_data,
    input  req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
  );

  modport slave (
    input  req_valid, req_tag, req_data,
    output req_ready, cdb_valid, cdb_tag, cdb_data, cdb_src, err_tag0
  );
endinterface

// File: rtl/rr_pick.sv
// Rotating priority encoder. The search starts at i_start and wraps modulo N.
// The first set request bit wins and is returned one-hot.
module rr_pick #(
  parameter int N  = 6,
  parameter int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [SW-1:0] i_start,
  output logic [N-1:0]  o_grant
);
  localparam logic [SW:0] N_VAL = (SW+1)'(N);

  logic [SW:0]   w_sum;
  logic [SW-1:0] w_idx;
  logic          w_found;

  // NOTE: every variable written here gets a default before the loop, so no path leaves it unassigned (no latch).
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int off = 0; off < N; off++) begin
      w_sum = {1'b0, i_start} + (SW+1)'(off);
      if (w_sum >= N_VAL) w_sum = w_sum - N_VAL;
      w_idx = w_sum[SW-1:0];
      if (!w_found && i_req[w_idx]) begin
        o_grant[w_idx] = 1'b1;
        w_found        = 1'b1;
      end
    end
  end
endmodule

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one-hot same-cycle grant and registered broadcast; tag-0 grants retire silently and set a sticky error.
// Optional macro CDB_MEM_PRIO_EN: memory (requester NREQ-1) always wins and does not move the pointer.
module cdb_arbiter #(
  parameter int NREQ       = cdb_pkg::NREQ,
  parameter int TAG_WIDTH  = cdb_pkg::TAG_WIDTH,
  parameter int DATA_WIDTH = cdb_pkg::DATA_WIDTH
) (
  input logic           clk,
  input logic           reset,
  cdb_arbiter_if.slave  bus
);
  localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [SW-1:0] LAST_IDX = SW'(NREQ - 1);

  cdb_pkg::cdb_bcast_t r_bcast;
  logic [SW-1:0]       r_src;
  logic [SW-1:0]       r_last_grant;
  logic                r_err_tag0;

  logic [NREQ-1:0]       w_req;
  logic [NREQ-1:0]       w_rr_grant;
  logic [NREQ-1:0]       w_grant;
  logic [SW-1:0]         w_start;
  logic [SW-1:0]         w_idx;
  logic [TAG_WIDTH-1:0]  w_tag;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_any;
  logic                  w_bcast;
  logic                  w_mem_prio;

  // Holding requests off during reset keeps any handshake from happening then.
  assign w_req   = reset ? bus.req_valid : '0;
  assign w_start = (r_last_grant == LAST_IDX) ? '0 : r_last_grant + SW'(1);

  rr_pick #(.N(NREQ), .SW(SW)) u_rr_pick (
    .i_req   (w_req),
    .i_start (w_start),
    .o_grant (w_rr_grant)
  );

`ifdef CDB_MEM_PRIO_EN
  assign w_mem_prio = w_req[NREQ-1];
  assign w_grant    = w_mem_prio ? {1'b1, {(NREQ-1){1'b0}}} : w_rr_grant;
`else
  assign w_mem_prio = 1'b0;
  assign w_grant    = w_rr_grant;
`endif

  always_comb begin
    w_idx  = '0;
    w_tag  = '0;
    w_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant[i]) begin
        w_idx  = SW'(i);
        w_tag  = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
        w_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_any   = |w_grant;
  assign w_bcast = w_any && (w_tag != '0);

  // NOTE: state registers use non-blocking assignments, so every flop samples the pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_bcast      <= '0;
      r_src        <= '0;
      r_err_tag0   <= 1'b0;
      r_last_grant <= LAST_IDX;
    end else begin
      r_bcast.valid <= w_bcast;
      r_bcast.tag   <= w_bcast ? w_tag  : '0;
      r_bcast.data  <= w_bcast ? w_data : '0;
      r_src         <= w_bcast ? w_idx  : '0;
      if (w_any && !w_bcast) r_err_tag0 <= 1'b1;
      if (w_any && !w_mem_prio) r_last_grant <= w_idx;
    end
  end

  assign bus.req_ready = w_grant;
  assign bus.cdb_valid = r_bcast.valid;
  assign bus.cdb_tag   = r_bcast.tag;
  assign bus.cdb_data  = r_bcast.data;
  assign bus.cdb_src   = r_src;
  assign bus.err_tag0  = r_err_tag0;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a table of grant vectors, directed corner sequences, and random
// traffic scored against a modulo-arithmetic round-robin model.
module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int N  = NREQ;
  localparam int TW = TAG_WIDTH;
  localparam int DW = DATA_WIDTH;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NREQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) bus ();

  cdb_arbiter #(.NREQ(N), .TAG_WIDTH(TW), .DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Standard stimulus: requester i carries tag i+1 and data 0xA0+i.
  task automatic drive_std(input logic [N-1:0] rv);
    for (int i = 0; i < N; i++) begin
      bus.req_tag[i*TW +: TW]  = TW'(i + 1);
      bus.req_data[i*DW +: DW] = DW'(32'hA0 + i);
    end
    bus.req_valid = rv;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive_std('1);
    #1;
    check("ready_in_reset", bus.req_ready, '0);
    tick();
    tick();
    check("rst_cdb_valid", bus.cdb_valid, 0);
    check("rst_cdb_tag", bus.cdb_tag, 0);
    check("rst_cdb_data", bus.cdb_data, 0);
    check("rst_cdb_src", bus.cdb_src, 0);
    check("rst_err_tag0", bus.err_tag0, 0);
    bus.req_valid = '0;
    reset = 1'b1;
  endtask

  function automatic int onehot_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Checks the registered broadcast that should follow a cycle granting 'idx' with the standard tags.
  task automatic check_std_bcast(input string name, input int idx);
    if (idx >= 0) begin
      check({name, "_valid"}, bus.cdb_valid, 1);
      check({name, "_tag"}, bus.cdb_tag, 64'(idx + 1));
      check({name, "_data"}, bus.cdb_data, 64'(32'hA0 + idx));
      check({name, "_src"}, bus.cdb_src, 64'(idx));
    end else begin
      check({name, "_valid"}, bus.cdb_valid, 0);
      check({name, "_tag"}, bus.cdb_tag, 0);
      check({name, "_data"}, bus.cdb_data, 0);
    end
  endtask

  typedef struct {
    logic [N-1:0] rv;
    logic [N-1:0] ready;
  } vec_t;

  vec_t vecs[14];

  // Random-phase model state
  logic          pend[N];
  logic [TW-1:0] tg[N];
  logic [DW-1:0] dt[N];
  int            wait_cnt[N];
  int            m_last;
  logic          m_err;

  initial begin
    vecs[0]  = '{6'b111111, 6'b000001};
    vecs[1]  = '{6'b111111, 6'b000010};
    vecs[2]  = '{6'b111111, 6'b000100};
    vecs[3]  = '{6'b111111, 6'b001000};
    vecs[4]  = '{6'b111111, 6'b010000};
    vecs[5]  = '{6'b111111, 6'b100000};
    vecs[6]  = '{6'b111111, 6'b000001};
    vecs[7]  = '{6'b000000, 6'b000000};
    vecs[8]  = '{6'b100100, 6'b000100};
    vecs[9]  = '{6'b100001, 6'b100000};
    vecs[10] = '{6'b100001, 6'b000001};
    vecs[11] = '{6'b100000, 6'b100000};
    vecs[12] = '{6'b001010, 6'b000010};
    vecs[13] = '{6'b001010, 6'b001000};

    reset = 1'b0;
    bus.req_valid = '0;
    bus.req_tag   = '0;
    bus.req_data  = '0;
    tick();
    do_reset();

    // Single request from adder 0
    bus.req_valid = 6'b000001;
    bus.req_tag[0 +: TW]  = 4'h3;
    bus.req_data[0 +: DW] = 32'h11;
    #1;
    check("single_ready", bus.req_ready, 6'b000001);
    tick();
    check("single_valid", bus.cdb_valid, 1);
    check("single_tag", bus.cdb_tag, 3);
    check("single_data", bus.cdb_data, 32'h11);
    check("single_src", bus.cdb_src, 0);
    bus.req_valid = '0;
    tick();
    check_std_bcast("idle", -1);

`ifdef CDB_MEM_PRIO_EN
    do_reset();
    for (int c = 0; c < 3; c++) begin
      drive_std(6'b100011);
      #1;
      check("memprio_ready", bus.req_ready, 6'b100000);
      tick();
      check_std_bcast("memprio_bc", 5);
    end
    drive_std(6'b000011);
    #1;
    check("memprio_after", bus.req_ready, 6'b000001);
    tick();
    check_std_bcast("memprio_after_bc", 0);
`else
    // Fairness, idle hold and wrap table, starting from last_grant = NREQ-1
    do_reset();
    for (int k = 0; k < 14; k++) begin
      drive_std(vecs[k].rv);
      #1;
      check($sformatf("vec%0d_ready", k), bus.req_ready, vecs[k].ready);
      tick();
      check_std_bcast($sformatf("vec%0d_bc", k), onehot_idx(vecs[k].ready));
    end
`endif

    // Tag 0 from adder 2: retires, no broadcast, sticky error
    bus.req_valid = '0;
    tick();
    drive_std(6'b000100);
    bus.req_tag[2*TW +: TW] = '0;
    #1;
    check("tag0_ready", bus.req_ready, 6'b000100);
    tick();
    check("tag0_cdb_valid", bus.cdb_valid, 0);
    check("tag0_err", bus.err_tag0, 1);
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("tag0_err_sticky", bus.err_tag0, 1);
    end
    do_reset();

    // Reset asserted while a broadcast is in flight
    drive_std(6'b000010);
    #1;
    check("midrst_grant", bus.req_ready, 6'b000010);
    tick();
    check("midrst_bc_valid", bus.cdb_valid, 1);
    reset = 1'b0;
    #1;
    check("midrst_ready_low", bus.req_ready, 0);
    tick();
    check("midrst_dropped", bus.cdb_valid, 0);
    check("midrst_src", bus.cdb_src, 0);
    reset = 1'b1;
    drive_std('1);
    #1;
    check("midrst_last5", bus.req_ready, 6'b000001);
    tick();
    bus.req_valid = '0;

    // Random traffic against the reference model
    do_reset();
    m_last = N - 1;
    m_err  = 1'b0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 1'b0;
      wait_cnt[i] = 0;
    end
    for (int cyc = 0; cyc < 400; cyc++) begin
      int exp_idx;
      logic [N-1:0] exp_ready;
      logic exp_v;
      logic [TW-1:0] exp_t;
      logic [DW-1:0] exp_d;
      int exp_s;

      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          tg[i] = TW'($urandom);
          dt[i] = DW'($urandom);
          wait_cnt[i] = 0;
        end
        bus.req_valid[i]         = pend[i];
        bus.req_tag[i*TW +: TW]  = tg[i];
        bus.req_data[i*DW +: DW] = dt[i];
      end

      exp_idx = -1;
`ifdef CDB_MEM_PRIO_EN
      if (pend[N-1]) exp_idx = N - 1;
`endif
      for (int off = 1; off <= N; off++) begin
        int j;
        j = (m_last + off) % N;
        if (exp_idx < 0 && pend[j]) exp_idx = j;
      end
      exp_ready = (exp_idx >= 0) ? (N'(1) << exp_idx) : '0;
      #1;
      check("rand_ready", bus.req_ready, exp_ready);

      exp_v = 1'b0; exp_t = '0; exp_d = '0; exp_s = 0;
      if (exp_idx >= 0) begin
        if (tg[exp_idx] != '0) begin
          exp_v = 1'b1;
          exp_t = tg[exp_idx];
          exp_d = dt[exp_idx];
          exp_s = exp_idx;
        end else begin
          m_err = 1'b1;
        end
`ifdef CDB_MEM_PRIO_EN
        if (exp_idx != N - 1) m_last = exp_idx;
`else
        m_last = exp_idx;
        check("rand_starvation_bound", 64'(wait_cnt[exp_idx] < N), 1);
`endif
        pend[exp_idx] = 1'b0;
      end
      for (int i = 0; i < N; i++) if (pend[i]) wait_cnt[i]++;

      tick();
      check("rand_cdb_valid", bus.cdb_valid, exp_v);
      check("rand_cdb_tag", bus.cdb_tag, exp_t);
      check("rand_cdb_data", bus.cdb_data, exp_d);
      check("rand_cdb_src", bus.cdb_src, 64'(exp_s));
      check("rand_err_tag0", bus.err_tag0, m_err);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
